// File: rtl/tc_pl_cap_buff_fill.sv
// Buffer-fill responder: decimates the sample stream into capture RAM while buff_en is high.
// Optional fill timeout watchdog enabled by defining CAP_FILL_TIMEOUT_EN.
module tc_pl_cap_buff_fill #(
  parameter int DW = 16,
  parameter int AW = 12
`ifdef CAP_FILL_TIMEOUT_EN
  , parameter int TMO = 65535
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          buff_en,
  output logic          buff_cmpt,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic [15:0]   decim,
  input  logic [AW:0]   cap_len,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW:0]   wr_cnt,
  output logic          cap_err
);

  typedef enum logic [1:0] {IDLE, ARM, FILL, DONE} state_t;

  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [15:0]     ratio_q, ratio_d;
  logic [15:0]     dc_q, dc_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     wr_cnt_q, wr_cnt_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic            cmpt_q, cmpt_d;
  logic            keep;
`ifdef CAP_FILL_TIMEOUT_EN
  logic [31:0]     tmo_q, tmo_d;
  logic            err_q, err_d;
`endif

  // Zero and anything beyond the buffer depth both mean "fill the whole buffer".
  function automatic logic [AW:0] sat_len(input logic [AW:0] l);
    if (l == '0 || l > DEPTH) return DEPTH;
    return l;
  endfunction

  function automatic logic [15:0] eff_ratio(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    len_d    = len_q;
    dc_d     = dc_q;
    wr_cnt_d = wr_cnt_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cmpt_d   = 1'b0;
    keep     = 1'b0;
`ifdef CAP_FILL_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (buff_en) begin
          state_d  = ARM;
          dc_d     = '0;
          wr_cnt_d = '0;
          addr_d   = '0;
`ifdef CAP_FILL_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      ARM: begin
        ratio_d  = eff_ratio(decim);
        len_d    = sat_len(cap_len);
        wr_cnt_d = '0;
        dc_d     = '0;
`ifdef CAP_FILL_TIMEOUT_EN
        err_d    = 1'b0;
        tmo_d    = '0;
`endif
        state_d  = buff_en ? FILL : IDLE;
      end
      FILL: begin
        if (!buff_en) begin
          state_d = IDLE;
        end else begin
          if (din_vld) begin
            dc_d = (dc_q == ratio_q - 16'd1) ? 16'd0 : dc_q + 16'd1;
            keep = (dc_q == 16'd0);
          end
          if (keep) begin
            wr_en_d  = 1'b1;
            data_d   = din;
            addr_d   = wr_cnt_q[AW-1:0];
            wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (wr_cnt_q + CNT_ONE == len_q) state_d = DONE;
          end
`ifdef CAP_FILL_TIMEOUT_EN
          // Watchdog only counts cycles without a strobe; a completed fill wins over a timeout.
          tmo_d = din_vld ? 32'd0 : tmo_q + 32'd1;
          if (!din_vld && (tmo_q + 32'd1 == 32'(TMO)) && state_d == FILL) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      DONE: begin
        if (!buff_en) state_d = IDLE;
        else          cmpt_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ratio_q  <= 16'd1;
      len_q    <= DEPTH;
      dc_q     <= '0;
      wr_cnt_q <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cmpt_q   <= 1'b0;
`ifdef CAP_FILL_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      len_q    <= len_d;
      dc_q     <= dc_d;
      wr_cnt_q <= wr_cnt_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cmpt_q   <= cmpt_d;
`ifdef CAP_FILL_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  assign buff_cmpt   = cmpt_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = data_q;
  assign wr_cnt      = wr_cnt_q;
`ifdef CAP_FILL_TIMEOUT_EN
  assign cap_err     = err_q;
`else
  assign cap_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tc_pl_cap_buff_fill.sv
// Directed self-checking bench for tc_pl_cap_buff_fill with a 16-word buffer.
module tb_tc_pl_cap_buff_fill;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          buff_en;
  logic          buff_cmpt;
  logic [DW-1:0] din;
  logic          din_vld;
  logic [15:0]   decim;
  logic [AW:0]   cap_len;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW:0]   wr_cnt;
  logic          cap_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int s      = 0;
  int cmpt_cyc;
  int addr_q[$];
  int data_q[$];
  int wcyc_q[$];

  tc_pl_cap_buff_fill #(
    .DW(DW),
    .AW(AW)
`ifdef CAP_FILL_TIMEOUT_EN
    , .TMO(20)
`endif
  ) dut (
    .clk(clk), .rst(rst), .buff_en(buff_en), .buff_cmpt(buff_cmpt),
    .din(din), .din_vld(din_vld), .decim(decim), .cap_len(cap_len),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .wr_cnt(wr_cnt), .cap_err(cap_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/complete monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (ram_wr_en) begin
      addr_q.push_back(int'(ram_wr_addr));
      data_q.push_back(int'(ram_wr_data));
      wcyc_q.push_back(cyc);
    end
    if (buff_cmpt && cmpt_cyc < 0) cmpt_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int qa(input int i);
    return (i < addr_q.size()) ? addr_q[i] : -1;
  endfunction
  function automatic int qd(input int i);
    return (i < data_q.size()) ? data_q[i] : -1;
  endfunction
  function automatic int qc(input int i);
    return (i < wcyc_q.size()) ? wcyc_q[i] : -1;
  endfunction

  task automatic start_fill();
    addr_q.delete();
    data_q.delete();
    wcyc_q.delete();
    cmpt_cyc = -1;
    buff_en  = 1'b1;
    tick();
    tick();
    s = cyc;
  endtask

  task automatic stream(input int ncyc, input int gap, input int base);
    for (int i = 0; i < ncyc; i++) begin
      din_vld = (i % gap == 0);
      din     = DW'(base + i / gap);
      tick();
    end
    din_vld = 1'b0;
  endtask

  task automatic release_en();
    buff_en = 1'b0;
    tick();
    chk("cmpt_drop", 32'(buff_cmpt), 32'd0);
  endtask

  initial begin
    rst = 1'b0; buff_en = 1'b0; din = '0; din_vld = 1'b0; decim = 16'd1; cap_len = '0;
    cmpt_cyc = -1;
    tick(); tick();
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_addr",  32'(ram_wr_addr), 32'd0);
    chk("rst_data",  32'(ram_wr_data), 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_cmpt",  32'(buff_cmpt), 32'd0);
    chk("rst_err",   32'(cap_err), 32'd0);
    rst = 1'b1;
    tick();

    // Basic fill
    decim = 16'd1; cap_len = 5'd8;
    start_fill();
    stream(12, 1, 'h100);
    tick();
    chk("basic_nwr", 32'(addr_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("basic_addr", 32'(qa(i)), 32'(i));
      chk("basic_data", 32'(qd(i)), 32'('h100 + i));
    end
    chk("basic_lat", 32'(qc(0)), 32'(s + 1));
    chk("basic_cmpt_cyc", 32'(cmpt_cyc), 32'(qc(7) + 1));
    chk("basic_wr_cnt", 32'(wr_cnt), 32'd8);
    chk("basic_cmpt", 32'(buff_cmpt), 32'd1);
    chk("basic_err", 32'(cap_err), 32'd0);
    release_en();

    // Decimation by 3, then decim=0
    decim = 16'd3; cap_len = 5'd4;
    start_fill();
    stream(20, 1, 0);
    chk("dec3_nwr", 32'(addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("dec3_addr", 32'(qa(i)), 32'(i));
      chk("dec3_data", 32'(qd(i)), 32'(3 * i));
    end
    release_en();
    decim = 16'd0;
    start_fill();
    stream(10, 1, 0);
    chk("dec0_nwr", 32'(addr_q.size()), 32'd4);
    chk("dec0_data3", 32'(qd(3)), 32'd3);
    release_en();

    // Full depth: cap_len=0 and saturating cap_len=20 (changed mid-fill, must not matter)
    decim = 16'd1; cap_len = 5'd0;
    start_fill();
    stream(24, 1, 'h40);
    chk("full0_nwr", 32'(addr_q.size()), 32'd16);
    chk("full0_last_addr", 32'(qa(15)), 32'd15);
    chk("full0_last_data", 32'(qd(15)), 32'h4f);
    chk("full0_wr_cnt", 32'(wr_cnt), 32'd16);
    release_en();
    cap_len = 5'd20;
    start_fill();
    cap_len = 5'd2;
    stream(24, 1, 'h40);
    chk("full20_nwr", 32'(addr_q.size()), 32'd16);
    chk("full20_wr_cnt", 32'(wr_cnt), 32'd16);
    release_en();

    // Abort after 3 writes
    cap_len = 5'd8;
    start_fill();
    stream(3, 1, 'h200);
    buff_en = 1'b0;
    din_vld = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    din_vld = 1'b0;
    chk("abort_nwr", 32'(addr_q.size()), 32'd3);
    chk("abort_wr_cnt", 32'(wr_cnt), 32'd3);
    chk("abort_cmpt_seen", 32'(cmpt_cyc), 32'hffffffff);

    // Hold after DONE, then release and re-arm
    cap_len = 5'd2;
    start_fill();
    stream(4, 1, 'h300);
    din_vld = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    din_vld = 1'b0;
    chk("hold_nwr", 32'(addr_q.size()), 32'd2);
    chk("hold_cmpt", 32'(buff_cmpt), 32'd1);
    release_en();
    chk("rel_nwr", 32'(addr_q.size()), 32'd2);
    cap_len = 5'd3;
    start_fill();
    stream(5, 1, 'h500);
    chk("rearm_addr0", 32'(qa(0)), 32'd0);
    chk("rearm_data0", 32'(qd(0)), 32'h500);
    chk("rearm_nwr", 32'(addr_q.size()), 32'd3);
    release_en();

    // Gapped input: strobe every 5th cycle
    cap_len = 5'd4;
    start_fill();
    stream(20, 5, 'h600);
    tick();
    chk("gap_nwr", 32'(addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("gap_cyc", 32'(qc(i)), 32'(s + 5 * i + 1));
      chk("gap_data", 32'(qd(i)), 32'('h600 + i));
    end
    chk("gap_cmpt", 32'(buff_cmpt), 32'd1);
    release_en();

    // Async reset mid-fill
    cap_len = 5'd8;
    start_fill();
    stream(3, 1, 'h700);
    rst = 1'b0;
    #1;
    chk("arst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("arst_addr", 32'(ram_wr_addr), 32'd0);
    chk("arst_data", 32'(ram_wr_data), 32'd0);
    chk("arst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("arst_cmpt", 32'(buff_cmpt), 32'd0);
    tick();
    buff_en = 1'b0;
    rst = 1'b1;
    tick();
    cap_len = 5'd2;
    start_fill();
    stream(4, 1, 'h800);
    chk("post_rst_lat", 32'(qc(0)), 32'(s + 1));
    chk("post_rst_addr0", 32'(qa(0)), 32'd0);
    chk("post_rst_nwr", 32'(addr_q.size()), 32'd2);
    release_en();

`ifdef CAP_FILL_TIMEOUT_EN
    // Timeout: two samples then silence
    cap_len = 5'd8;
    start_fill();
    stream(2, 1, 'h900);
    for (int i = 0; i < 40 && !buff_cmpt; i++) tick();
    chk("tmo_cmpt", 32'(buff_cmpt), 32'd1);
    chk("tmo_err", 32'(cap_err), 32'd1);
    chk("tmo_wr_cnt", 32'(wr_cnt), 32'd2);
    release_en();
    chk("tmo_err_hold", 32'(cap_err), 32'd1);
    start_fill();
    chk("tmo_err_clr", 32'(cap_err), 32'd0);
    release_en();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tc_pl_cap_buff_fill.md
Name: tc_pl_cap_buff_fill

Overview:
- Buffer-fill responder on the buff_en/buff_cmpt handshake issued by the capture sequencer.
- While buff_en is high, it decimates an incoming sample stream and writes cap_len samples into an external simple-dual-port RAM, then raises buff_cmpt.
- Sits between the ADC sample interface and the capture RAM write port. The downstream transfer stage reads the buffer afterwards.

Parameters:
- DW, 16, sample and RAM data width.
- AW, 12, RAM address width; buffer depth is 2^AW words.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low; all state clears while rst=0.
- buff_en  in  1  level request from the sequencer; high = fill buffer, low = abort or release.
- buff_cmpt  out  1  level; high when the fill is complete, held until buff_en falls.
- din  in  DW  sample data.
- din_vld  in  1  sample strobe; one sample per high cycle.
- decim  in  16  decimation ratio; 0 and 1 both mean keep every sample. Latched at ARM.
- cap_len  in  AW+1  samples to store; 0 means 2^AW. Values above 2^AW saturate to 2^AW. Latched at ARM.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_addr  out  AW  RAM write address, starting at 0.
- ram_wr_data  out  DW  RAM write data.
- wr_cnt  out  AW+1  samples written in the current or last fill.
- cap_err  out  1  fill ended by timeout; meaningful only with the optional feature, otherwise tied 0.

Behaviour:
- Reset values: buff_cmpt=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, wr_cnt=0, cap_err=0; state=IDLE.
- State machine: IDLE, ARM, FILL, DONE.
- IDLE:
  - buff_en=1 -> ARM.
  - All counters and ram_wr_addr are cleared on the IDLE->ARM transition.
- ARM (exactly one cycle):
  - Latch decim as the effective ratio D = max(decim,1).
  - Latch cap_len as the effective length L (0 or >2^AW -> 2^AW).
  - Clear wr_cnt and cap_err.
  - Go to FILL.
  - din_vld during ARM is ignored.
- FILL:
  - Each din_vld cycle increments the decimation counter dc (0..D-1, wraps to 0).
  - The sample is kept when dc==0 at that strobe, so the 1st, (D+1)th, ... samples are stored.
  - A kept sample at cycle t produces ram_wr_en=1 at t+1, with ram_wr_data=din(t) and ram_wr_addr=wr_cnt(t). wr_cnt increments at t+1.
  - Write latency is 1 cycle; ram_wr_en is a single-cycle pulse per sample.
  - Back-to-back din_vld with D=1 gives a write every cycle.
  - When the L-th write issues at t+1, the state moves to DONE and buff_cmpt=1 at t+2.
  - Samples after the L-th kept sample are ignored.
- DONE:
  - buff_cmpt held at 1, no writes.
  - buff_en=0 -> IDLE, and buff_cmpt=0 in the same cycle the state returns to IDLE, i.e. one cycle after buff_en is sampled low.
- Abort: buff_en=0 in ARM or FILL -> IDLE on the next edge.
  - A write already scheduled for that edge still completes.
  - No further writes; buff_cmpt stays 0; wr_cnt keeps the partial count.
- Re-arm: a new fill requires buff_en low for at least one cycle (IDLE). buff_en held high after DONE never restarts a fill.
- Address wrap: not possible, since L<=2^AW. The last address written is L-1.
- wr_cnt reaches 2^AW when L=2^AW, hence AW+1 bits.
- decim and cap_len changes outside ARM have no effect.
- Async rst mid-fill: immediate clear of all outputs; RAM contents are undefined to the consumer.

Optional Feature:
- Macro CAP_FILL_TIMEOUT_EN.
- Defined:
  - Parameter TMO, default 65535, is added.
  - A 32-bit idle counter runs in FILL and clears on every din_vld.
  - When it reaches TMO, go to DONE, set buff_cmpt=1 and cap_err=1 (cap_err holds until the next ARM). wr_cnt shows the partial count.
- Undefined:
  - No counter, no parameter; cap_err is a constant 0.
  - FILL waits indefinitely for samples.

Test Plan:
- Basic fill: DW=16, AW=4, decim=1, cap_len=8; raise buff_en; din_vld continuous with din=0x100+n -> 8 writes, addr 0..7, data 0x100..0x107; buff_cmpt rises 1 cycle after the 8th write; wr_cnt=8; din 0x108+ not written.
- Decimation: decim=3, cap_len=4, continuous din=n from 0 -> data 0,3,6,9 at addr 0..3; decim=0 behaves as decim=1.
- Full depth: AW=4, cap_len=0 -> 16 writes, last addr 15, wr_cnt=16; cap_len=20 -> also 16.
- Abort and release: drop buff_en after 3 writes -> no further ram_wr_en, buff_cmpt never 1, wr_cnt=3. Hold buff_en high after DONE for 10 cycles -> no restart. Drop it -> buff_cmpt=0 next cycle; raise again -> new fill from addr 0.
- Gapped input and reset: din_vld every 5th cycle with cap_len=4 -> writes 1 cycle after each strobe. Assert rst low mid-fill -> all outputs 0 immediately, state IDLE after release.
- Timeout (CAP_FILL_TIMEOUT_EN, TMO=20): 2 samples then none -> buff_cmpt=1 and cap_err=1 after 20 idle cycles, wr_cnt=2. Next ARM clears cap_err.
